// File: rtl/dmem_responder.sv
// Single-port data memory responder with a valid/ready request and response handshake.
// Each request is answered after a fixed LATENCY, and illegal requests return an error response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_32 = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With LATENCY = 0 the commit edge is the accepting edge, so the live request is used in IDLE.
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_illegal;
  logic             commit;
  logic             mem_we;

  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_idx     = cur_addr[2 +: IDX_W];
    cur_illegal = (cur_addr[1:0] != 2'b00)
               || ({2'b00, cur_addr[31:2]} >= DEPTH_32)
               || (cur_we && (cur_be == 4'b0000));
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      err_d   = cur_illegal;
      rdata_d = (cur_illegal || cur_we) ? 32'h0 : mem_q[cur_idx];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset on the commit edge abandons the store, so the write is gated by rst.
  assign mem_we = commit && cur_we && !cur_illegal && !rst;

  // NOTE: the array has no reset; contents stay undefined until written, which keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) begin
          mem_q[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main features
// and a LATENCY=0 instance for zero-wait timing and back-to-back spacing.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_we = 1'b0;
  logic [31:0] z_req_addr = 32'h0;
  logic [31:0] z_req_wdata = 32'h0;
  logic [3:0]  z_req_be = 4'h0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b0;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  // One full transaction on the LATENCY=2 instance; called one time unit after an edge, in IDLE.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input string name,
                      output logic [31:0] rd, output logic er);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = b;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before: got %b expected 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (n != 2) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d edges expected 2", name, n);
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s release: got valid=%b ready=%b expected valid=0 ready=1",
               name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b expected 0/00000000/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b/%b expected 1/1", req_ready, z_req_ready);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "store_10", rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_10_rsp: got rdata=%h err=%b expected 00000000/0", rd, er);
    end
    xact(1'b0, 32'h10, 32'h0, 4'hF, "load_10", rd, er);
    tests_run++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_10: got rdata=%h err=%b expected deadbeef/0", rd, er);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd;
    logic er;
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, "store_20_full", rd, er);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, "store_20_be5", rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_20_be5_rsp: got rdata=%h err=%b expected 00000000/0", rd, er);
    end
    // Load with be=0 checks that loads ignore the byte enables.
    xact(1'b0, 32'h20, 32'h0, 4'h0, "load_20", rd, er);
    tests_run++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_20_merged: got rdata=%h err=%b expected 11bb33dd/0", rd, er);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    logic er;
    xact(1'b0, 32'h13, 32'h0, 4'hF, "load_13", rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_load: got rdata=%h err=%b expected 00000000/1", rd, er);
    end
    xact(1'b1, 32'h0, 32'h12345678, 4'hF, "store_0", rd, er);
    xact(1'b1, 32'h400, 32'h55555555, 4'hF, "store_oob", rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      tests_failed++;
      $display("FAIL oob_store: got rdata=%h err=%b expected 00000000/1", rd, er);
    end
    xact(1'b0, 32'h0, 32'h0, 4'hF, "load_0", rd, er);
    tests_run++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL oob_no_write: got rdata=%h err=%b expected 12345678/0", rd, er);
    end
    xact(1'b1, 32'h10, 32'h0, 4'h0, "store_be0", rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      tests_failed++;
      $display("FAIL be0_store: got rdata=%h err=%b expected 00000000/1", rd, er);
    end
    xact(1'b0, 32'h10, 32'h0, 4'hF, "load_10_after", rd, er);
    tests_run++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL be0_no_write: got rdata=%h err=%b expected deadbeef/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic er;
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_response: got rsp_valid=%b expected 1 within 40 cycles", rsp_valid);
    end
    // A store presented while the response is stalled must be ignored.
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_be = 4'hF;
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB33DD || rsp_err !== 1'b0
          || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b ready=%b expected 1/11bb33dd/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'h0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
    end
    xact(1'b0, 32'h20, 32'h0, 4'hF, "load_20_after_bp", rd, er);
    tests_run++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ignored_store: got rdata=%h err=%b expected 11bb33dd/0", rd, er);
    end
  endtask

  task automatic test_latency0();
    z_rsp_ready = 1'b0;
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h8;
    z_req_wdata = 32'h0BADF00D; z_req_be = 4'hF;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_we = 1'b0;
    tests_run++;
    if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'h0 || z_rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat0_store: got valid=%b rdata=%h err=%b expected 1/00000000/0",
               z_rsp_valid, z_rsp_rdata, z_rsp_err);
    end
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h8; z_req_be = 4'h0;
    @(posedge clk); #1;
    tests_run++;
    if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'h0BADF00D || z_rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat0_load: got valid=%b rdata=%h err=%b expected 1/0badf00d/0",
               z_rsp_valid, z_rsp_rdata, z_rsp_err);
    end
    // Request and response ready held high: acceptance alternates with handshake.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (z_req_ready !== ((i % 2) == 0) || z_rsp_valid !== ((i % 2) == 1)) begin
        tests_failed++;
        $display("FAIL lat0_b2b%0d: got ready=%b valid=%b expected %b/%b",
                 i, z_req_ready, z_rsp_valid, (i % 2) == 0, (i % 2) == 1);
      end
      @(posedge clk); #1;
    end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    logic er;
    xact(1'b1, 32'h40, 32'h0, 4'hF, "store_40_zero", rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rst_wait%0d: got valid=%b ready=%b expected 0/1", i, rsp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    xact(1'b0, 32'h40, 32'h0, 4'hF, "load_40", rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_no_write: got rdata=%h err=%b expected 00000000/0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_store_load();
    test_byte_enables();
    test_illegal();
    test_backpressure();
    test_latency0();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
